// File: rtl/monster_hit_ctrl.sv
// monster_hit_ctrl: turns raw missile/monster pixel collisions into at most one
// accepted hit per frame, tracks health and post-hit immunity, and exposes
// registered pulses for the missile and the health bar.
module monster_hit_ctrl #(
  parameter int MAX_HEALTH    = 32,
  parameter int INVULN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       collision,
  input  logic       game_restart,
  output logic       got_hit,
  output logic       missile_consume,
  output logic [7:0] health,
  output logic       monster_dead,
  output logic       monster_flash
);

  localparam logic [7:0] MAX_H = 8'(MAX_HEALTH);
  localparam logic [7:0] INV_F = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {READY, PENDING, COOLDOWN, DEAD} state_t;

  state_t     state;
  logic [7:0] frame_cnt;
  logic [7:0] hit_health;
  logic       accept;

  // Health after one accepted hit, saturating at zero.
  assign hit_health = (health == 8'd0) ? 8'd0 : health - 8'd1;

  // A hit lands on the frame boundary: either a latched collision sees
  // startOfFrame, or a fresh collision arrives together with it.
  assign accept = ((state == PENDING) && startOfFrame) ||
                  ((state == READY) && collision && startOfFrame);

  // Hit FSM with all outputs registered; reset and restart share one path.
  always_ff @(posedge clk) begin
    if (reset || game_restart) begin
      state           <= READY;
      health          <= MAX_H;
      frame_cnt       <= 8'd0;
      got_hit         <= 1'b0;
      missile_consume <= 1'b0;
      monster_dead    <= 1'b0;
      monster_flash   <= 1'b0;
    end else begin
      got_hit         <= 1'b0;
      missile_consume <= 1'b0;
      if (accept) begin
        got_hit <= 1'b1;
        // Only a fresh collision still owes the missile its consume pulse.
        if (state == READY) missile_consume <= 1'b1;
        health       <= hit_health;
        monster_dead <= (hit_health == 8'd0);
        if (hit_health == 8'd0) begin
          state         <= DEAD;
          frame_cnt     <= 8'd0;
          monster_flash <= 1'b0;
        end else begin
          state         <= COOLDOWN;
          frame_cnt     <= INV_F;
          monster_flash <= INV_F[0];
        end
      end else begin
        case (state)
          READY: begin
            if (collision) begin
              state           <= PENDING;
              missile_consume <= 1'b1;
            end
          end
          PENDING: begin
            // Extra collisions this frame are absorbed silently.
          end
          COOLDOWN: begin
            if (startOfFrame) begin
              if (frame_cnt <= 8'd1) begin
                state         <= READY;
                frame_cnt     <= 8'd0;
                monster_flash <= 1'b0;
              end else begin
                frame_cnt     <= frame_cnt - 8'd1;
                monster_flash <= ~frame_cnt[0];
              end
            end
          end
          DEAD: begin
            health        <= 8'd0;
            monster_dead  <= 1'b1;
            monster_flash <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monster_hit_ctrl.sv
// tb_monster_hit_ctrl: directed scenarios plus randomized frames, two DUT
// configurations driven in lockstep and compared against a frame-level model.
module tb_monster_hit_ctrl;

  logic       clk = 1'b0;
  logic       reset, sof, col, rst_g;
  logic       hit0, cons0, dead0, fl0;
  logic       hit1, cons1, dead1, fl1;
  logic [7:0] hp0, hp1;

  always #5 clk = ~clk;

  monster_hit_ctrl u0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .collision(col),
    .game_restart(rst_g), .got_hit(hit0), .missile_consume(cons0),
    .health(hp0), .monster_dead(dead0), .monster_flash(fl0)
  );

  monster_hit_ctrl #(.MAX_HEALTH(2), .INVULN_FRAMES(1)) u1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .collision(col),
    .game_restart(rst_g), .got_hit(hit1), .missile_consume(cons1),
    .health(hp1), .monster_dead(dead1), .monster_flash(fl1)
  );

  int n_chk = 0, n_pass = 0;
  int n_hit0 = 0, n_cons0 = 0, n_hit1 = 0, n_cons1 = 0;

  // model: health, immunity frames left, and "a hit is owed this frame"
  int m_hp[2], m_left[2];
  bit m_armed[2], e_hit[2], e_cons[2];
  int maxh[2] = '{32, 2};
  int invf[2] = '{8, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model(input int i);
    e_hit[i]  = 0;
    e_cons[i] = 0;
    if (reset || rst_g) begin
      m_hp[i] = maxh[i]; m_left[i] = 0; m_armed[i] = 0;
    end else if (m_hp[i] == 0) begin
      // dead: nothing reacts
    end else if (m_left[i] > 0) begin
      if (sof) m_left[i]--;
    end else begin
      if (col && !m_armed[i]) begin
        e_cons[i] = 1; m_armed[i] = 1;
      end
      if (m_armed[i] && sof) begin
        e_hit[i] = 1; m_hp[i]--; m_armed[i] = 0;
        m_left[i] = (m_hp[i] > 0) ? invf[i] : 0;
      end
    end
  endtask

  task automatic step(input bit c, input bit s, input bit r, input bit g);
    col = c; sof = s; reset = r; rst_g = g;
    @(posedge clk); #1;
    model(0); model(1);
    chk("hit0",   hit0,  e_hit[0]);
    chk("cons0",  cons0, e_cons[0]);
    chk("hp0",    hp0,   m_hp[0]);
    chk("dead0",  dead0, m_hp[0] == 0);
    chk("flash0", fl0,   m_left[0] % 2);
    chk("hit1",   hit1,  e_hit[1]);
    chk("cons1",  cons1, e_cons[1]);
    chk("hp1",    hp1,   m_hp[1]);
    chk("dead1",  dead1, m_hp[1] == 0);
    chk("flash1", fl1,   m_left[1] % 2);
    n_hit0 += hit0; n_cons0 += cons0; n_hit1 += hit1; n_cons1 += cons1;
  endtask

  initial begin
    int flen;
    col = 0; sof = 0; reset = 1; rst_g = 0;

    // reset state
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    chk("rst_hp", hp0, 32); chk("rst_flash", fl0, 0); chk("rst_dead", dead0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);

    // single hit: 5 collision cycles then the frame boundary
    n_hit0 = 0; n_cons0 = 0;
    repeat (5) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("single_hit_pulse", hit0, 1);
    step(0, 0, 0, 0);
    chk("single_hits", n_hit0, 1); chk("single_cons", n_cons0, 1);
    chk("single_hp", hp0, 31); chk("single_flash", fl0, 0);

    // immunity: 8 frames of collisions, last one on the expiring boundary
    n_hit0 = 0; n_cons0 = 0;
    for (int k = 1; k <= 8; k++) begin
      repeat (3) step(1, 0, 0, 0);
      step(k == 8, 1, 0, 0);
      if (k < 8) chk("immune_flash", fl0, (8 - k) % 2);
    end
    chk("immune_hits", n_hit0, 0); chk("immune_cons", n_cons0, 0);
    chk("immune_end_flash", fl0, 0);
    repeat (2) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("frame9_hit", hit0, 1); chk("frame9_hp", hp0, 30);
    step(0, 0, 0, 0);

    // same-cycle collision and boundary in READY
    repeat (8) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("same_hit", hit0, 1); chk("same_cons", cons0, 1); chk("same_hp", hp0, 29);
    step(0, 0, 0, 0);
    chk("same_hp_once", hp0, 29); chk("same_hit_once", hit0, 0);

    // restart coincident with the boundary while a hit is pending
    repeat (8) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    chk("restart_hit", hit0, 0); chk("restart_hp", hp0, 32); chk("restart_cons", cons0, 0);
    step(0, 0, 0, 0);
    chk("restart_after", hit0, 0);

    // death on the small instance, then collisions are ignored
    step(0, 0, 1, 0);
    step(1, 1, 0, 0); chk("death_hp1a", hp1, 1);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0); chk("death_hp1", hp1, 0); chk("death_flag", dead1, 1);
    n_hit1 = 0; n_cons1 = 0;
    repeat (4) begin step(1, 0, 0, 0); step(1, 1, 0, 0); end
    chk("dead_hits", n_hit1, 0); chk("dead_cons", n_cons1, 0); chk("dead_hp", hp1, 0);

    // reset during cooldown at health 20
    step(0, 0, 1, 0);
    for (int h = 0; h < 12; h++) begin
      step(1, 1, 0, 0);
      if (h < 11) repeat (8) step(0, 1, 0, 0);
    end
    step(0, 1, 0, 0);
    chk("cd_hp", hp0, 20); chk("cd_flash", fl0, 1);
    step(0, 0, 1, 0);
    chk("midrst_hp", hp0, 32); chk("midrst_flash", fl0, 0);
    step(1, 0, 0, 0); chk("midrst_cons", cons0, 1);
    step(0, 1, 0, 0); chk("midrst_hit", hit0, 1); chk("midrst_hp2", hp0, 31);

    // randomized frames
    flen = 0;
    repeat (5000) begin
      bit s, c, r, g;
      s = (flen == 0);
      if (s) flen = $urandom_range(0, 9); else flen--;
      c = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 599) == 0);
      g = ($urandom_range(0, 999) == 0);
      step(c, s, r, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
